change_dispenser: RTL and testbench

Pays out change after a vend. Captures the 5-bit change amount when the vend strobe fires, then drives a coin hopper one coin at a time over a valid/ack handshake. Coins are chosen greedily, largest first, using the same 2-bit coin codes the vending controller accepts on its coin input. It sits downstream of the vending controller: `start` connects to the controller's `out`, and `change` connects to its `change`.

---
 rtl/cafe_pkg.sv | 21 ++
 rtl/change_coin_select.sv | 36 +++
 rtl/change_dispenser.sv | 137 +++++++++++++
 tb/tb_change_dispenser.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cafe_pkg.sv
// Shared vending-cafe definitions: money width, coin codes and the change dispenser state encoding.
package cafe_pkg;

  localparam int MONEY_W = 5;
  typedef logic [MONEY_W-1:0] money_t;

  typedef logic [1:0] coin_code_t;
  localparam coin_code_t COIN_NONE = 2'b00;
  localparam coin_code_t COIN_01   = 2'b01;
  localparam coin_code_t COIN_10   = 2'b10;
  localparam coin_code_t COIN_11   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE,
    ST_FAULT
  } disp_state_e;

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: the largest-value coin that fits in the remainder and whose hopper still has stock.
module change_coin_select
  import cafe_pkg::*;
(
  input  money_t     remaining,
  input  logic [2:0] hopper_empty,
  input  money_t     val_01,
  input  money_t     val_10,
  input  money_t     val_11,
  output coin_code_t code,
  output money_t     value,
  output logic       found
);

  money_t vals [3];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    code    = COIN_NONE;
    value   = '0;
    found   = 1'b0;
    vals[0] = val_01;
    vals[1] = val_10;
    vals[2] = val_11;
    // Zero-valued coins are never eligible, otherwise the payout could loop forever.
    for (int i = 0; i < 3; i++) begin
      if (!hopper_empty[i] && vals[i] != '0 && vals[i] <= remaining &&
          (!found || vals[i] > value)) begin
        code  = coin_code_t'(i + 1);
        value = vals[i];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a latched change amount one coin at a time over a valid/ack handshake to the coin hoppers.
module change_dispenser
  import cafe_pkg::*;
#(
  parameter int unsigned VAL_01      = 1,
  parameter int unsigned VAL_10      = 2,
  parameter int unsigned VAL_11      = 5,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MONEY_W-1:0] change,
  input  logic [2:0]         hopper_empty,
  input  logic               eject_ack,
  input  logic               clear,
  output logic               eject_valid,
  output logic [1:0]         eject_code,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [MONEY_W-1:0] shortfall,
  output logic [MONEY_W-1:0] coins_out
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  disp_state_e state_q, state_d;
  money_t      remaining_q, remaining_d;
  coin_code_t  code_q, code_d;
  money_t      value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  money_t      shortfall_q, shortfall_d;
  money_t      coins_q, coins_d;

  coin_code_t  sel_code;
  money_t      sel_value;
  logic        sel_found;

  change_coin_select u_select (
    .remaining    (remaining_q),
    .hopper_empty (hopper_empty),
    .val_01       (money_t'(VAL_01)),
    .val_10       (money_t'(VAL_10)),
    .val_11       (money_t'(VAL_11)),
    .code         (sel_code),
    .value        (sel_value),
    .found        (sel_found)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    code_d      = code_q;
    value_d     = value_q;
    cnt_d       = cnt_q;
    shortfall_d = shortfall_q;
    coins_d     = coins_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = change;
          coins_d     = '0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remaining_q == '0) begin
          state_d = ST_DONE;
        end else if (sel_found) begin
          code_d  = sel_code;
          value_d = sel_value;
          cnt_d   = '0;
          state_d = ST_EJECT;
        end else begin
          shortfall_d = remaining_q;
          state_d     = ST_FAULT;
        end
      end
      ST_EJECT: begin
        // An ack arriving on the timeout cycle still counts as a delivered coin.
        if (eject_ack) begin
          remaining_d = remaining_q - value_q;
          if (coins_q != '1) coins_d = coins_q + money_t'(1);
          state_d = ST_SELECT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
            shortfall_d = remaining_q;
            state_d     = ST_FAULT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: begin
        if (clear) begin
          shortfall_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      code_q      <= COIN_NONE;
      value_q     <= '0;
      cnt_q       <= '0;
      shortfall_q <= '0;
      coins_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      code_q      <= code_d;
      value_q     <= value_d;
      cnt_q       <= cnt_d;
      shortfall_q <= shortfall_d;
      coins_q     <= coins_d;
    end
  end

  assign eject_valid = (state_q == ST_EJECT);
  assign eject_code  = code_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign fault       = (state_q == ST_FAULT);
  assign shortfall   = shortfall_q;
  assign coins_out   = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser with hand-computed coin sequences.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] change;
  logic [2:0] hopper_empty;
  logic       eject_ack;
  logic       clear;
  logic       eject_valid;
  logic [1:0] eject_code;
  logic       busy;
  logic       done;
  logic       fault;
  logic [4:0] shortfall;
  logic [4:0] coins_out;

  int n_tests = 0;
  int n_fail  = 0;

  int codes[$];
  int done_cnt;
  int valid_cycles;
  int unstable;
  bit fault_seen;
  bit finished;

  change_dispenser dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .change       (change),
    .hopper_empty (hopper_empty),
    .eject_ack    (eject_ack),
    .clear        (clear),
    .eject_valid  (eject_valid),
    .eject_code   (eject_code),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .shortfall    (shortfall),
    .coins_out    (coins_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic vend(input logic [4:0] amt, input logic [2:0] empty);
    hopper_empty = empty;
    change       = amt;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  // Acks the hopper ack_lat cycles into each eject_valid (ack_lat < 0: never), optionally
  // pulses start at cycle pulse_at, and stops when the dispenser goes idle or faults.
  task automatic run(input int ack_lat, input int pulse_at, input int budget, input string tag);
    int wait_c = 0;
    int cur    = 0;
    codes.delete();
    done_cnt     = 0;
    valid_cycles = 0;
    unstable     = 0;
    fault_seen   = 1'b0;
    finished     = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      eject_ack = 1'b0;
      start     = (cyc == pulse_at);
      if (cyc == pulse_at) change = 5'd31;
      if (done) done_cnt++;
      if (eject_valid) begin
        valid_cycles++;
        if (wait_c == 0) cur = int'(eject_code);
        else if (int'(eject_code) != cur) unstable++;
        if (wait_c == ack_lat) begin
          eject_ack = 1'b1;
          codes.push_back(int'(eject_code));
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end
      if (fault) begin
        fault_seen = 1'b1;
        finished   = 1'b1;
        break;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    eject_ack = 1'b0;
    start     = 1'b0;
    if (!finished) check({tag, "_budget_expired"}, 1, 0);
  endtask

  task automatic check_codes(input string tag, input int exp[$]);
    check({tag, "_ncoins"}, codes.size(), exp.size());
    for (int i = 0; i < exp.size() && i < codes.size(); i++)
      check($sformatf("%s_code%0d", tag, i), codes[i], exp[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; change = '0; hopper_empty = '0;
    eject_ack = 1'b0; clear = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", eject_valid, 0);
    check("rst_coins", coins_out, 0);
    check("rst_fault", fault, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // change=0: done during N+1..N+2, busy falls after N+2
    vend(5'd0, 3'b000);
    check("zero_sel_busy", busy, 1);
    check("zero_sel_done", done, 0);
    @(posedge clk); #1;
    check("zero_done", done, 1);
    @(posedge clk); #1;
    check("zero_done_fall", done, 0);
    check("zero_idle", busy, 0);

    // 13 = 5+5+2+1
    vend(5'd13, 3'b000);
    check("c13_sel_valid", eject_valid, 0);
    run(0, -1, 100, "c13");
    check_codes("c13", '{3, 3, 2, 1});
    check("c13_coins", coins_out, 4);
    check("c13_done", done_cnt, 1);
    check("c13_fault", fault_seen, 0);

    // 8 with the 5-coin hopper empty = 2+2+2+2, slower acks
    vend(5'd8, 3'b100);
    run(2, -1, 100, "c8");
    check_codes("c8", '{2, 2, 2, 2});
    check("c8_coins", coins_out, 4);
    check("c8_done", done_cnt, 1);

    // 3 with 1 and 2 hoppers empty: immediate fault
    vend(5'd3, 3'b011);
    run(0, -1, 20, "c3");
    check("c3_valid", valid_cycles, 0);
    check("c3_fault", fault, 1);
    check("c3_shortfall", shortfall, 3);
    check("c3_coins", coins_out, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("c3_clr_fault", fault, 0);
    check("c3_clr_busy", busy, 0);
    check("c3_clr_short", shortfall, 0);

    // 5 with no ack: 15 valid cycles of code 11, then fault
    vend(5'd5, 3'b000);
    run(-1, -1, 40, "to");
    check("to_valid_cycles", valid_cycles, 15);
    check("to_unstable", unstable, 0);
    check("to_code", eject_code, 3);
    check("to_fault", fault, 1);
    check("to_shortfall", shortfall, 5);
    check("to_valid_off", eject_valid, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("to_clr_short", shortfall, 0);

    // ack on the last allowed cycle wins over the timeout
    vend(5'd5, 3'b000);
    run(14, -1, 40, "late");
    check_codes("late", '{3});
    check("late_fault", fault_seen, 0);
    check("late_done", done_cnt, 1);

    // start pulse mid-payout of 7 is ignored: 5+2
    vend(5'd7, 3'b000);
    run(1, 1, 100, "c7");
    check_codes("c7", '{3, 2});
    check("c7_done", done_cnt, 1);
    check("c7_coins", coins_out, 2);

    // reset mid-EJECT
    vend(5'd13, 3'b000);
    @(posedge clk); #1;
    check("mid_valid", eject_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", eject_valid, 0);
    check("mid_rst_code", eject_code, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_coins", coins_out, 0);
    check("mid_rst_short", shortfall, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    vend(5'd2, 3'b000);
    run(0, -1, 40, "c2");
    check_codes("c2", '{2});
    check("c2_coins", coins_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
